// File: rtl/fc_weight_loader.sv
// fc_weight_loader: packs a serial valid/ready stream of weight words into
// rows, writes the rows into a row-wide RAM, and serves a registered
// address->weights read port to the layer sequencer.
module fc_weight_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int INPUT_NODES  = 400,
    parameter int OUTPUT_NODES = 120,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               in_valid,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               in_ready,
    output logic                               loaded,
    output logic [ADDR_WIDTH-1:0]              row_count,
    input  logic [ADDR_WIDTH-1:0]              address,
    output logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights
);

    localparam int ROW_W = DATA_WIDTH * OUTPUT_NODES;
    localparam int COL_W = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1;
    localparam int IDX_W = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1;
    localparam logic [COL_W-1:0]      LAST_COL = COL_W'(OUTPUT_NODES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(INPUT_NODES - 1);
    localparam logic [ADDR_WIDTH-1:0] NUM_ROWS = ADDR_WIDTH'(INPUT_NODES);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [COL_W-1:0]       col;
    logic                   accept;
    logic                   row_done;
    logic                   last_row;
    logic                   clear;
    logic [DATA_WIDTH-1:0]  row_buf [OUTPUT_NODES];
    logic [ROW_W-1:0]       wr_row;
    logic [ROW_W-1:0]       mem [INPUT_NODES];

    // Handshake decode from the registered state so in_ready never loops back
    // through the next-state logic.
    assign accept   = in_valid && (state == LOAD);
    assign row_done = accept && (col == LAST_COL);
    assign last_row = (row_count == LAST_ROW);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus state-decoded in_ready/loaded; start only acts outside LOAD.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        loaded     = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                    clear      = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (row_done && last_row) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                loaded = 1'b1;
                if (start) begin
                    next_state = LOAD;
                    clear      = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Column and row counters; row_count stops at INPUT_NODES instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row_count <= '0;
        end else if (clear) begin
            col       <= '0;
            row_count <= '0;
        end else if (accept) begin
            if (col == LAST_COL) begin
                col <= '0;
                if (row_count != NUM_ROWS) begin
                    row_count <= row_count + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Row buffer slot capture; stale slots after an abort are overwritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf[col] <= in_data;
        end
    end

    // Assemble the full row: buffered slots plus the word arriving this cycle in the top slot.
    always_comb begin
        wr_row = '0;
        for (int i = 0; i < OUTPUT_NODES; i++) begin
            wr_row[i*DATA_WIDTH +: DATA_WIDTH] = (i == OUTPUT_NODES - 1) ? in_data : row_buf[i];
        end
    end

    // RAM write on the edge that completes a row; contents survive reset.
    always_ff @(posedge clk) begin
        if (row_done && (row_count < NUM_ROWS)) begin
            mem[row_count[IDX_W-1:0]] <= wr_row;
        end
    end

    // Registered read, read-before-write on a same-row collision; out-of-range rows read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            weights <= '0;
        end else if (address < NUM_ROWS) begin
            weights <= mem[address[IDX_W-1:0]];
        end else begin
            weights <= '0;
        end
    end

endmodule

// File: tb/tb_fc_weight_loader.sv
// Bench for fc_weight_loader with 4 rows of 3 words: a word-count model of the
// loader checked every cycle, plus directed literal expectations per scenario.
module tb_fc_weight_loader;

    localparam int DW = 32;
    localparam int IN = 4;
    localparam int ON = 3;
    localparam int AW = 9;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_ready;
    logic           loaded;
    logic [AW-1:0]  row_count;
    logic [AW-1:0]  address;
    logic [DW*ON-1:0] weights;

    int checks = 0;
    int errors = 0;
    int ready_cycles = 0;
    logic chk_en = 1'b0;

    fc_weight_loader #(
        .DATA_WIDTH(DW),
        .INPUT_NODES(IN),
        .OUTPUT_NODES(ON),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .loaded(loaded),
        .row_count(row_count),
        .address(address),
        .weights(weights)
    );

    always #5 clk = ~clk;

    // Model: loader as a count of words taken in the current load.
    logic [31:0] mm [IN][ON];
    logic        mk [IN];
    logic [31:0] wbuf [ON];
    int          m_nwords = 0;
    logic        m_loading = 1'b0;
    logic        m_loaded = 1'b0;
    logic [DW*ON-1:0] m_w = '0;
    logic        m_wk = 1'b0;

    initial begin
        for (int r = 0; r < IN; r++) mk[r] = 1'b0;
    end

    function automatic logic [DW*ON-1:0] pack_model(input int r);
        return {mm[r][2], mm[r][1], mm[r][0]};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_loading = 1'b0;
            m_loaded  = 1'b0;
            m_nwords  = 0;
            m_w       = '0;
            m_wk      = 1'b1;
        end else begin
            if (address >= AW'(IN)) begin
                m_w  = '0;
                m_wk = 1'b1;
            end else if (mk[address]) begin
                m_w  = pack_model(int'(address));
                m_wk = 1'b1;
            end else begin
                m_wk = 1'b0;
            end
            if (m_loading) begin
                if (in_valid) begin
                    wbuf[m_nwords % ON] = in_data;
                    m_nwords++;
                    if (m_nwords % ON == 0) begin
                        for (int c = 0; c < ON; c++) mm[m_nwords/ON - 1][c] = wbuf[c];
                        mk[m_nwords/ON - 1] = 1'b1;
                    end
                    if (m_nwords == IN*ON) begin
                        m_loading = 1'b0;
                        m_loaded  = 1'b1;
                    end
                end
            end else if (start) begin
                m_loading = 1'b1;
                m_loaded  = 1'b0;
                m_nwords  = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 96'(in_ready), 96'(m_loading));
            check("loaded", 96'(loaded), 96'(m_loaded));
            check("row_count", 96'(row_count), 96'(m_nwords / ON));
            if (m_wk) check("weights", 96'(weights), 96'(m_w));
            if (in_ready) ready_cycles++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input int gap);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; address = '1;
        @(posedge clk); #1 chk_en = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 96'(in_ready), 96'd0);
        check("rst_loaded", 96'(loaded), 96'd0);
        check("rst_row_count", 96'(row_count), 96'd0);
        check("rst_weights", 96'(weights), 96'd0);

        // 1: back-to-back stream 1..12
        ready_cycles = 0;
        pulse_start();
        for (int i = 1; i <= 12; i++) send(32'(i), 0);
        check("t1_loaded", 96'(loaded), 96'd1);
        check("t1_row_count", 96'(row_count), 96'd4);
        check("t1_ready_cycles", 96'(ready_cycles), 96'd12);
        address = 2;
        tick();
        check("t1_row2", 96'(weights), {32'd9, 32'd8, 32'd7});
        check("model_row2", 96'(pack_model(2)), {32'd9, 32'd8, 32'd7});

        // 2: in_valid toggling, loaded after 23 cycles
        pulse_start();
        for (int i = 1; i <= 11; i++) send(32'(i), 1);
        check("t2_not_loaded_22", 96'(loaded), 96'd0);
        send(32'd12, 0);
        check("t2_loaded_23", 96'(loaded), 96'd1);
        address = 1;
        tick();
        check("t2_row1", 96'(weights), {32'd6, 32'd5, 32'd4});

        // 3: out-of-range addresses read zero
        address = 4;
        tick();
        check("t3_addr4", 96'(weights), 96'd0);
        address = '1;
        tick();
        check("t3_addr_ones", 96'(weights), 96'd0);

        // 4: reset after 5 words
        pulse_start();
        for (int i = 1; i <= 5; i++) send(32'(i), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_loaded", 96'(loaded), 96'd0);
        check("t4_in_ready", 96'(in_ready), 96'd0);
        check("t4_row_count", 96'(row_count), 96'd0);
        in_valid = 1'b1; in_data = 32'hDEAD;
        repeat (3) tick();
        in_valid = 1'b0;
        check("t6_idle_row_count", 96'(row_count), 96'd0);
        address = 0;
        tick();
        check("t4_row0_kept", 96'(weights), {32'd3, 32'd2, 32'd1});
        pulse_start();
        for (int i = 0; i < 12; i++) send(32'h100 + 32'(i), 0);
        check("t4_reload_done", 96'(loaded), 96'd1);
        address = 3;
        tick();
        check("t4_row3", 96'(weights), {32'h10B, 32'h10A, 32'h109});

        // 5: read row 0 across its own rewrite
        address = 0;
        tick();
        check("t5_row0_before", 96'(weights), {32'h102, 32'h101, 32'h100});
        pulse_start();
        send(32'h200, 0);
        send(32'h201, 0);
        send(32'h202, 0);
        check("t5_old_at_write", 96'(weights), {32'h102, 32'h101, 32'h100});
        tick();
        check("t5_new_after", 96'(weights), {32'h202, 32'h201, 32'h200});

        // 6: start mid-LOAD and in_valid in DONE are ignored
        start = 1'b1;
        send(32'h203, 0);
        start = 1'b0;
        check("t6_mid_start_rows", 96'(row_count), 96'd1);
        for (int i = 4; i < 12; i++) send(32'h200 + 32'(i), 0);
        check("t6_loaded", 96'(loaded), 96'd1);
        check("t6_row_count", 96'(row_count), 96'd4);
        in_valid = 1'b1; in_data = 32'hBAD;
        repeat (4) tick();
        in_valid = 1'b0;
        check("t6_done_row_count", 96'(row_count), 96'd4);
        address = 3;
        tick();
        check("t6_row3", 96'(weights), {32'h20B, 32'h20A, 32'h209});
        address = 1;
        tick();
        check("t6_row1", 96'(weights), {32'h205, 32'h204, 32'h203});

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
